// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: fetch state encoding and IF-stage constants shared with IF/ID and hazard logic
package if_fetch_unit_pkg;
  typedef enum logic {S_REQ, S_FULL} fetch_state_t;
  localparam logic [31:0] NOP_INSTR    = 32'h0;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_SIZE  = 32'h0000_4000;
endpackage

// File: rtl/if_pc_next.sv
// if_pc_next: next-PC select for a consumed fetch (live redirect, pending target, or pc+4)
module if_pc_next (
  input  logic [31:0] pc,
  input  logic        pending,
  input  logic [31:0] pending_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_add4,
  output logic [31:0] next_pc
);
  always_comb begin
    pc_add4 = pc + 32'd4;
    next_pc = redirect_valid ? redirect_pc : pending ? pending_pc : pc_add4;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage with PC, one-outstanding imem request and delay-slot redirect.
// Define IF_ADDR_CHECK_EN to add the fetch address check and the fetch_adel port.
module if_fetch_unit import if_fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef IF_ADDR_CHECK_EN
  , parameter logic [31:0] IM_BASE = DEF_IM_BASE,
  parameter logic [31:0] IM_SIZE = DEF_IM_SIZE
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_add4_out
`ifdef IF_ADDR_CHECK_EN
  , output logic      fetch_adel
`endif
);
  fetch_state_t state;
  logic [31:0] pc, buffer, pending_pc, pc_next, pc_add4;
  logic pending, addr_ok;
`ifdef IF_ADDR_CHECK_EN
  logic adel;
  assign addr_ok = pc[1:0] == 2'b00 && pc >= IM_BASE && pc - IM_BASE < IM_SIZE;
  assign fetch_adel = adel;
`else
  assign addr_ok = 1'b1;
`endif
  if_pc_next u_pc_next (
    .pc(pc), .pending(pending), .pending_pc(pending_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_add4(pc_add4), .next_pc(pc_next)
  );
  assign imem_req    = state == S_REQ && addr_ok;
  assign imem_addr   = pc;
  assign fetch_valid = state == S_FULL;
  assign instr_out   = fetch_valid ? buffer : NOP_INSTR;
  assign pc_out      = pc;
  assign pc_add4_out = pc_add4;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      buffer     <= NOP_INSTR;
      pending    <= 1'b0;
      pending_pc <= '0;
`ifdef IF_ADDR_CHECK_EN
      adel       <= 1'b0;
`endif
    end else if (state == S_REQ) begin
      // the in-flight fetch is the delay slot; the target waits for the next fetch
      if (!stall && redirect_valid) begin
        pending    <= 1'b1;
        pending_pc <= redirect_pc;
      end
`ifdef IF_ADDR_CHECK_EN
      if (!addr_ok) begin
        buffer <= NOP_INSTR;
        adel   <= 1'b1;
        state  <= S_FULL;
      end else
`endif
      if (imem_ack) begin
        buffer <= imem_rdata;
        state  <= S_FULL;
      end
    end else if (!stall) begin
      pc      <= pc_next;
      pending <= 1'b0;
      state   <= S_REQ;
`ifdef IF_ADDR_CHECK_EN
      adel    <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch sequencing, stalls, delay-slot redirects and reset.
module tb_if_fetch_unit;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata, imem_addr, instr_out, pc_out, pc_add4_out;
  logic imem_req, fetch_valid;
  int n_checks = 0, n_fail = 0;
`ifdef IF_ADDR_CHECK_EN
  logic fetch_adel;
`endif
  always #5 clk = ~clk;
  // memory returns a word tagged with the low half of its address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction
  assign imem_rdata = word_at(imem_addr);
  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
    .instr_out(instr_out), .pc_out(pc_out), .pc_add4_out(pc_add4_out)
`ifdef IF_ADDR_CHECK_EN
    , .fetch_adel(fetch_adel)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h3000);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc", pc_out, 32'h3000);
    check("rst_pc4", pc_add4_out, 32'h3004);
    imem_ack = 1'b1;
    step();
    check("zw_valid", {31'd0, fetch_valid}, 32'd1);
    check("zw_instr", instr_out, 32'hA5A5_3000);
    check("zw_pc4", pc_add4_out, 32'h3004);
    check("zw_noreq", {31'd0, imem_req}, 32'd0);
    step();
    check("zw_addr1", imem_addr, 32'h3004);
    check("zw_gap", {31'd0, fetch_valid}, 32'd0);
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("dly_req", {31'd0, imem_req}, 32'd1);
      check("dly_addr", imem_addr, 32'h3004);
      check("dly_valid", {31'd0, fetch_valid}, 32'd0);
      check("dly_instr", instr_out, 32'h0);
      imem_ack = i == 3;
      step();
    end
    check("dly_data", instr_out, 32'hA5A5_3004);
    step();
    check("addr2", imem_addr, 32'h3008);
    step();
    check("full3008", pc_add4_out, 32'h300C);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hDEAD_BEE0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stl_valid", {31'd0, fetch_valid}, 32'd1);
      check("stl_instr", instr_out, 32'hA5A5_3008);
      check("stl_pc", pc_out, 32'h3008);
      check("stl_noreq", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("after_stall", imem_addr, 32'h300C);
    step();
    step();
    check("ds_addr", imem_addr, 32'h3010);
    imem_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3100;
    step();
    redirect_valid = 1'b0;
    check("ds_hold_addr", imem_addr, 32'h3010);
    check("ds_hold_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    step();
    check("ds_instr", instr_out, 32'hA5A5_3010);
    check("ds_pc", pc_out, 32'h3010);
    step();
    check("ds_target", imem_addr, 32'h3100);
    step();
    check("tgt_instr", instr_out, 32'hA5A5_3100);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3200;
    step();
    redirect_valid = 1'b0;
    check("full_redir", imem_addr, 32'h3200);
    step();
    check("full_redir_pc4", pc_add4_out, 32'h3204);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_add4_out, 32'h0);
    imem_ack = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_addr", imem_addr, 32'h3000);
    check("mid_rst_req", {31'd0, imem_req}, 32'd1);
    check("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
`ifdef IF_ADDR_CHECK_EN
    imem_ack = 1'b1;
    step();
    check("adel_clear", {31'd0, fetch_adel}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3002;
    step();
    redirect_valid = 1'b0;
    check("mis_noreq", {31'd0, imem_req}, 32'd0);
    step();
    check("mis_valid", {31'd0, fetch_valid}, 32'd1);
    check("mis_adel", {31'd0, fetch_adel}, 32'd1);
    check("mis_instr", instr_out, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000;
    step();
    redirect_valid = 1'b0;
    check("oor_noreq", {31'd0, imem_req}, 32'd0);
    step();
    check("oor_valid", {31'd0, fetch_valid}, 32'd1);
    check("oor_adel", {31'd0, fetch_adel}, 32'd1);
    check("oor_instr", instr_out, 32'h0);
    step();
    check("oor_consumed", {31'd0, fetch_adel}, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
